// File: rtl/onp_seq_if.sv
// Host/command bus between the RPN program sequencer and its environment.
// master = host + downstream calculator side, slave = sequencer side.
interface onp_seq_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic          wr;
  logic [AW-1:0] wraddr;
  logic [DW+1:0] wdata;
  logic          start;
  logic [AW:0]   len;
  logic          cmd_ready;
  logic          cmd_valid;
  logic          push;
  logic [DW-1:0] d;
  logic [1:0]    op;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW-1:0] pc;
  logic [AW:0]   depth;

  modport master (
    output wr, wraddr, wdata, start, len, cmd_ready,
    input  cmd_valid, push, d, op, busy, done, err, pc, depth
  );

  modport slave (
    input  wr, wraddr, wdata, start, len, cmd_ready,
    output cmd_valid, push, d, op, busy, done, err, pc, depth
  );
endinterface

// File: rtl/onp_sequencer.sv
// RPN program sequencer: issues push/op commands from program memory with shadow depth checking.
// Optional macro ONP_SEQ_NRST_EN adds onp_nrst, a one-cycle calculator clear after each start.
module onp_sequencer #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic clk,
  input  logic nrst,
`ifdef ONP_SEQ_NRST_EN
  output logic onp_nrst,
`endif
  onp_seq_if.slave bus
);

  // state | meaning
  // IDLE  | after reset, waiting for start
  // RUN   | issuing tokens from mem[pc]
  // DONE  | finished with final depth 1 (done=1)
  // ERR   | len==0, illegal token, or bad final depth (err=1)
  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

`ifdef ONP_SEQ_NRST_EN
  localparam bit NRST_EN = 1'b1;
`else
  localparam bit NRST_EN = 1'b0;
`endif

  localparam logic [AW:0] DEPTH_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE       = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] TWO       = {{(AW-1){1'b0}}, 2'b10};

  state_t        state_q, state_d;
  logic [AW:0]   idx_q, idx_d;
  logic [AW:0]   depth_q, depth_d;
  logic [AW:0]   len_q, len_d;
  logic          first_q, first_d;

  logic [DW+1:0] mem [2**AW];
  logic [DW+1:0] tok;
  logic [1:0]    kind;
  logic          legal;
  logic          cmd_valid;
  logic          accept;
  logic          last;
  logic [AW:0]   depth_upd;

  always_ff @(posedge clk) begin
    if (bus.wr && state_q != RUN) begin
      mem[bus.wraddr] <= bus.wdata;
    end
  end

  assign tok  = mem[idx_q[AW-1:0]];
  assign kind = tok[DW+1:DW];

  always_comb begin
    legal     = 1'b0;
    depth_upd = depth_q;
    unique case (kind)
      2'b00: begin
        legal     = depth_q < DEPTH_MAX;
        depth_upd = depth_q + ONE;
      end
      2'b01: begin
        legal     = depth_q >= ONE;
        depth_upd = depth_q;
      end
      default: begin
        legal     = depth_q >= TWO;
        depth_upd = depth_q - ONE;
      end
    endcase
  end

  // The NRST_EN blank cycle keeps the command bus quiet while the calculator clears.
  assign cmd_valid = (state_q == RUN) && legal && !first_q;
  assign accept    = cmd_valid && bus.cmd_ready;
  assign last      = idx_q == (len_q - ONE);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    len_d   = len_q;
    first_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (!legal) begin
          state_d = ERR;
        end else if (accept) begin
          idx_d   = idx_q + ONE;
          depth_d = depth_upd;
          if (last) begin
            state_d = (depth_upd == ONE) ? DONE : ERR;
          end
        end
      end
      default: begin
        if (bus.start) begin
          len_d   = bus.len;
          idx_d   = '0;
          depth_d = '0;
          first_d = NRST_EN;
          state_d = (bus.len == '0) ? ERR : RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      depth_q <= '0;
      len_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      len_q   <= len_d;
      first_q <= first_d;
    end
  end

  assign bus.cmd_valid = cmd_valid;
  assign bus.push      = cmd_valid && (kind == 2'b00);
  assign bus.d         = (cmd_valid && kind == 2'b00) ? tok[DW-1:0] : '0;
  assign bus.op        = (cmd_valid && kind != 2'b00) ? kind : 2'b00;
  assign bus.busy      = state_q == RUN;
  assign bus.done      = state_q == DONE;
  assign bus.err       = state_q == ERR;
  assign bus.pc        = idx_q[AW-1:0];
  assign bus.depth     = depth_q;

`ifdef ONP_SEQ_NRST_EN
  assign onp_nrst = ~first_q;
`endif

endmodule

// File: tb/tb_onp_sequencer.sv
// Self-checking bench for onp_sequencer: table of programs plus a reset-abort sequence.
// A scoreboard queue holds the commands each program should issue, in order.
module tb_onp_sequencer;

  localparam logic [17:0] NEG_T = {2'b01, 16'd0};
  localparam logic [17:0] ADD_T = {2'b10, 16'd0};
  localparam logic [17:0] MUL_T = {2'b11, 16'd0};
`ifdef ONP_SEQ_NRST_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif

  typedef struct {
    int               sel;
    int               len;
    logic [4:0][17:0] tok;
    bit               toggle;
    bit               poke;
    int               n_issue;
    int               exp_cycles;
    bit               exp_done;
    bit               exp_err;
    int               exp_depth;
    int               exp_pc;
    int               exp_result;
  } vec_t;

  logic        clk;
  logic        nrst;
  logic        wr;
  logic [9:0]  wraddr;
  logic [17:0] wdata;
  logic        start;
  logic [10:0] len;
  logic        cmd_ready;
  int          sel;

  int n_checks;
  int n_errors;
  logic [17:0] exp_q[$];
  int stk[8];
  int sp;

  onp_seq_if #(.AW(10), .DW(16)) ifm ();
  onp_seq_if #(.AW(2),  .DW(16)) ifs ();

  assign ifm.wr = wr;  assign ifm.wraddr = wraddr;      assign ifm.wdata = wdata;
  assign ifm.start = start; assign ifm.len = len;       assign ifm.cmd_ready = cmd_ready;
  assign ifs.wr = wr;  assign ifs.wraddr = wraddr[1:0]; assign ifs.wdata = wdata;
  assign ifs.start = start; assign ifs.len = len[2:0];  assign ifs.cmd_ready = cmd_ready;

`ifdef ONP_SEQ_NRST_EN
  logic onp_nrst_m, onp_nrst_s;
`endif

  onp_sequencer #(.AW(10), .DW(16)) dut_m (
    .clk(clk), .nrst(nrst),
`ifdef ONP_SEQ_NRST_EN
    .onp_nrst(onp_nrst_m),
`endif
    .bus(ifm)
  );

  onp_sequencer #(.AW(2), .DW(16)) dut_s (
    .clk(clk), .nrst(nrst),
`ifdef ONP_SEQ_NRST_EN
    .onp_nrst(onp_nrst_s),
`endif
    .bus(ifs)
  );

  logic        o_valid, o_push, o_busy, o_done, o_err;
  logic [15:0] o_d;
  logic [1:0]  o_op;
  int          o_pc, o_depth;

  always_comb begin
    if (sel == 0) begin
      o_valid = ifm.cmd_valid; o_push = ifm.push; o_d = ifm.d; o_op = ifm.op;
      o_busy = ifm.busy; o_done = ifm.done; o_err = ifm.err;
      o_pc = int'(ifm.pc); o_depth = int'(ifm.depth);
    end else begin
      o_valid = ifs.cmd_valid; o_push = ifs.push; o_d = ifs.d; o_op = ifs.op;
      o_busy = ifs.busy; o_done = ifs.done; o_err = ifs.err;
      o_pc = int'(ifs.pc); o_depth = int'(ifs.depth);
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] P(input int v);
    return {2'b00, 16'(v)};
  endfunction

  function automatic vec_t mk(input int s, input int l,
                              input logic [17:0] t0, input logic [17:0] t1,
                              input logic [17:0] t2, input logic [17:0] t3,
                              input logic [17:0] t4, input bit tg, input bit pk,
                              input int n, input int cyc, input bit dn, input bit er,
                              input int dep, input int pcv, input int res);
    vec_t v;
    v.sel = s; v.len = l;
    v.tok[0] = t0; v.tok[1] = t1; v.tok[2] = t2; v.tok[3] = t3; v.tok[4] = t4;
    v.toggle = tg; v.poke = pk; v.n_issue = n; v.exp_cycles = cyc;
    v.exp_done = dn; v.exp_err = er; v.exp_depth = dep; v.exp_pc = pcv;
    v.exp_result = res;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic calc(input logic push_i, input logic [1:0] op_i, input logic [15:0] d_i);
    if (push_i) begin
      if (sp < 8) begin stk[sp] = int'(d_i); sp++; end
    end else if (op_i == 2'b01) begin
      if (sp >= 1) stk[sp-1] = -stk[sp-1];
    end else if (sp >= 2) begin
      sp--;
      stk[sp-1] = (op_i == 2'b10) ? stk[sp-1] + stk[sp] : stk[sp-1] * stk[sp];
    end
  endtask

  task automatic take_cmd(input string tag);
    logic [17:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_unexpected_cmd"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_push"}, o_push, (e[17:16] == 2'b00));
      check({tag, "_cmd"}, {o_op, o_d}, e);
      calc(o_push, o_op, o_d);
    end
  endtask

  task automatic load(input vec_t v);
    for (int i = 0; i < v.len; i++) begin
      wr = 1'b1; wraddr = 10'(i); wdata = v.tok[i];
      step();
    end
    wr = 1'b0;
  endtask

  task automatic run_case(input int id, input vec_t v, input bit do_load);
    bit finished;
    bit held_v;
    logic [17:0] held;
    int nacc;
    int busy_cyc;
    string tag;
    tag = $sformatf("case%0d", id);
    sel = v.sel;
    if (do_load) load(v);
    for (int i = 0; i < v.n_issue; i++) exp_q.push_back(v.tok[i]);
    sp = 0;
    start = 1'b1; len = 11'(v.len);
    step();
    start = 1'b0;
    finished = 1'b0; held_v = 1'b0; held = '0; nacc = 0; busy_cyc = 0;
    for (int c = 0; c < 40 && !finished; c++) begin
      cmd_ready = v.toggle ? (c % 2 == 0) : 1'b1;
      wr = v.poke && (c == 1); wraddr = 10'd2; wdata = P(99);
      #1;
      if (!o_busy) begin
        finished = 1'b1;
      end else begin
        busy_cyc++;
        if (held_v) check({tag, "_stall_hold"}, {o_valid, o_op, o_d}, {1'b1, held});
        if (c == FIRST && v.n_issue > 0) check({tag, "_first_latency"}, o_valid, 1);
        if (o_valid && cmd_ready) begin
          nacc++;
          take_cmd(tag);
        end
        held_v = o_valid && !cmd_ready;
        held = {o_op, o_d};
        step();
      end
    end
    wr = 1'b0;
    cmd_ready = 1'b0;
    check({tag, "_terminated"}, finished, 1);
    check({tag, "_busy_cycles"}, busy_cyc, v.exp_cycles + ((v.len > 0) ? FIRST : 0));
    check({tag, "_accepted"}, nacc, v.n_issue);
    check({tag, "_done"}, o_done, v.exp_done);
    check({tag, "_err"}, o_err, v.exp_err);
    check({tag, "_depth"}, o_depth, v.exp_depth);
    if (v.exp_pc >= 0) check({tag, "_pc"}, o_pc, v.exp_pc);
    if (v.exp_result >= 0) begin
      check({tag, "_calc_depth"}, sp, 1);
      check({tag, "_result"}, stk[0], v.exp_result);
    end
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    exp_q.delete();
    step();
  endtask

  vec_t vecs[6];

  initial begin
    n_checks = 0; n_errors = 0; sp = 0; sel = 0;
    nrst = 1'b0; wr = 1'b0; wraddr = '0; wdata = '0;
    start = 1'b0; len = '0; cmd_ready = 1'b0;

    vecs[0] = mk(0, 5, P(3), P(4), ADD_T, P(5), MUL_T, 0, 0, 5, 5, 1, 0, 1, -1, 35);
    vecs[1] = mk(0, 1, ADD_T, NEG_T, NEG_T, NEG_T, NEG_T, 0, 0, 0, 1, 0, 1, 0, 0, -1);
    vecs[2] = mk(0, 5, P(3), P(4), ADD_T, P(5), MUL_T, 1, 1, 5, 9, 1, 0, 1, -1, 35);
    vecs[3] = mk(0, 2, P(1), P(2), NEG_T, NEG_T, NEG_T, 0, 0, 2, 2, 0, 1, 2, -1, -1);
    vecs[4] = mk(1, 5, P(7), P(7), P(7), P(7), P(7), 0, 0, 4, 5, 0, 1, 4, 0, -1);
    vecs[5] = mk(0, 0, NEG_T, NEG_T, NEG_T, NEG_T, NEG_T, 0, 0, 0, 0, 0, 1, 0, 0, -1);

    repeat (3) step();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);
    check("rst_valid", o_valid, 0);
    check("rst_depth", o_depth, 0);
    check("rst_pc", o_pc, 0);
    nrst = 1'b1;
    step();

    for (int i = 0; i < 6; i++) run_case(i, vecs[i], 1'b1);

    // Reset in the third RUN cycle, then rerun from the untouched memory.
    sel = 0;
    load(vecs[0]);
    exp_q.push_back(P(3));
    exp_q.push_back(P(4));
    sp = 0;
    start = 1'b1; len = 11'd5;
    step();
    start = 1'b0;
    for (int c = 0; c < 3 + FIRST; c++) begin
      cmd_ready = 1'b1;
      if (c == 2 + FIRST) nrst = 1'b0;
      #1;
      if (c >= FIRST && c < 2 + FIRST) take_cmd("rstrun");
      step();
    end
    check("rstrun_busy", o_busy, 0);
    check("rstrun_valid", o_valid, 0);
    check("rstrun_depth", o_depth, 0);
    check("rstrun_pc", o_pc, 0);
    check("rstrun_err", o_err, 0);
    check("rstrun_sb_empty", exp_q.size(), 0);
    exp_q.delete();
    nrst = 1'b1;
    cmd_ready = 1'b0;
    step();
    run_case(6, vecs[0], 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
